// File: rtl/st_rs_queue.sv
// -----------------------------------------------------------------------------
// st_rs_queue
// Multi-entry store reservation queue sitting between dispatch and the
// AGU / D-cache store port. Each entry captures its operands from the CDB,
// issues (oldest operand-ready first) to the AGU, absorbs the computed
// address, and waits for the ROB commit grant. Committed stores drain to
// memory strictly in program order from the head and survive a flush.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_flush                       kill every entry that is not yet committed
//   i_cache_stall                 D-cache busy, blocks the memory pop only
//   i_rs_we, i_rs_*               store allocation from dispatch (tag = ROB id,
//                                 src0 = address base, src1 = store data)
//   o_rs_write_rdy                queue not full
//   i_cdb_valid/tag/result        N_CDB flattened CDB broadcast ports
//   o_agu_read_rdy, o_agu_*       oldest operand-ready, un-issued entry
//   i_agu_re                      AGU accepts the offered entry
//   i_agu_valid/tag/result        AGU result (address), matched by ROB tag
//   i_commit_store_ids/vals       N_COMMIT flattened ROB store-commit ports
//   o_mem_read_rdy, o_mem_*       head entry ready to write memory
//   i_mem_re                      memory accepts the head entry
//   o_stq_count                   occupied entries
// -----------------------------------------------------------------------------
module st_rs_queue #(
    parameter int STQ_DEPTH  = 4,
    parameter int N_CDB      = 2,
    parameter int N_COMMIT   = 2,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_flush,
    input  logic                           i_cache_stall,
    input  logic                           i_rs_we,
    input  logic [TAG_WIDTH-1:0]           i_rs_tag,
    input  logic [TAG_WIDTH-1:0]           i_rs_src0_tag,
    input  logic                           i_rs_src0_rdy,
    input  logic [DATA_WIDTH-1:0]          i_rs_src0_data,
    input  logic [TAG_WIDTH-1:0]           i_rs_src1_tag,
    input  logic                           i_rs_src1_rdy,
    input  logic [DATA_WIDTH-1:0]          i_rs_src1_data,
    output logic                           o_rs_write_rdy,
    input  logic [N_CDB-1:0]               i_cdb_valid,
    input  logic [N_CDB*TAG_WIDTH-1:0]     i_cdb_tag,
    input  logic [N_CDB*DATA_WIDTH-1:0]    i_cdb_result,
    output logic                           o_agu_read_rdy,
    output logic [TAG_WIDTH-1:0]           o_agu_tag,
    output logic [DATA_WIDTH-1:0]          o_agu_src0_data,
    output logic [DATA_WIDTH-1:0]          o_agu_src1_data,
    input  logic                           i_agu_re,
    input  logic                           i_agu_valid,
    input  logic [TAG_WIDTH-1:0]           i_agu_tag,
    input  logic [DATA_WIDTH-1:0]          i_agu_result,
    input  logic [N_COMMIT*TAG_WIDTH-1:0]  i_commit_store_ids,
    input  logic [N_COMMIT-1:0]            i_commit_store_vals,
    output logic                           o_mem_read_rdy,
    output logic [TAG_WIDTH-1:0]           o_mem_tag,
    output logic [DATA_WIDTH-1:0]          o_mem_addr,
    output logic [DATA_WIDTH-1:0]          o_mem_data,
    output logic                           o_mem_agu_comp,
    input  logic                           i_mem_re,
    output logic [$clog2(STQ_DEPTH):0]     o_stq_count
);

    localparam int PW = $clog2(STQ_DEPTH);
    localparam int CW = $clog2(STQ_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(STQ_DEPTH);

    typedef enum logic [1:0] {
        ST_WAIT_REG  = 2'd0,
        ST_WAIT_AGU  = 2'd1,
        ST_ADDR_DONE = 2'd2
    } entry_state_t;

    // Entry storage (r_) and next-state values (w_*_n)
    logic [STQ_DEPTH-1:0]  r_valid, r_s0_rdy, r_s1_rdy, r_issued, r_agu_comp, r_perm;
    logic [STQ_DEPTH-1:0]  w_valid_n, w_s0_rdy_n, w_s1_rdy_n, w_issued_n, w_agu_comp_n, w_perm_n;
    logic [TAG_WIDTH-1:0]  r_tag [STQ_DEPTH];
    logic [TAG_WIDTH-1:0]  r_s0_tag [STQ_DEPTH];
    logic [TAG_WIDTH-1:0]  r_s1_tag [STQ_DEPTH];
    logic [DATA_WIDTH-1:0] r_s0_data [STQ_DEPTH];
    logic [DATA_WIDTH-1:0] r_s1_data [STQ_DEPTH];
    entry_state_t          r_state [STQ_DEPTH];
    logic [TAG_WIDTH-1:0]  w_tag_n [STQ_DEPTH];
    logic [TAG_WIDTH-1:0]  w_s0_tag_n [STQ_DEPTH];
    logic [TAG_WIDTH-1:0]  w_s1_tag_n [STQ_DEPTH];
    logic [DATA_WIDTH-1:0] w_s0_data_n [STQ_DEPTH];
    logic [DATA_WIDTH-1:0] w_s1_data_n [STQ_DEPTH];
    entry_state_t          w_state_n [STQ_DEPTH];

    logic [PW-1:0] r_head, r_tail, w_head_n, w_tail_n;
    logic [CW-1:0] r_count, w_count_n;

    logic [STQ_DEPTH-1:0]  w_commit_hit;
    logic                  w_issue_found;
    logic [PW-1:0]         w_issue_idx;
    logic                  w_issue_fire;
    logic [CW-1:0]         w_prefix;
    logic                  w_prefix_run;
    logic                  w_alloc;
    logic                  w_pop;
    logic                  w_byp_s0_rdy, w_byp_s1_rdy;
    logic [DATA_WIDTH-1:0] w_byp_s0_data, w_byp_s1_data;

    assign o_rs_write_rdy = (r_count != FULL_CNT);
    assign o_stq_count    = r_count;
    assign w_alloc        = i_rs_we && o_rs_write_rdy && !i_flush;
    assign w_issue_fire   = i_agu_re && w_issue_found && !i_flush;
    assign w_pop          = i_mem_re && o_mem_read_rdy && !i_cache_stall;

    // Per-entry commit match across all ROB commit ports
    always_comb begin
        w_commit_hit = '0;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            for (int k = 0; k < N_COMMIT; k++) begin
                if (r_valid[i] && i_commit_store_vals[k] &&
                    (i_commit_store_ids[k*TAG_WIDTH +: TAG_WIDTH] == r_tag[i])) begin
                    w_commit_hit[i] = 1'b1;
                end else begin
                    w_commit_hit[i] = w_commit_hit[i];
                end
            end
        end
    end

    // Oldest-first AGU selection: walk from head so the first hit is the oldest
    always_comb begin
        w_issue_found = 1'b0;
        w_issue_idx   = r_head;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            if (!w_issue_found && (CW'(i) < r_count) &&
                (r_state[r_head + PW'(i)] == ST_WAIT_AGU) && !r_issued[r_head + PW'(i)]) begin
                w_issue_found = 1'b1;
                w_issue_idx   = r_head + PW'(i);
            end else begin
                w_issue_found = w_issue_found;
            end
        end
    end

    // Length of the committed run starting at head; these entries survive a flush
    always_comb begin
        w_prefix     = '0;
        w_prefix_run = 1'b1;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            if (w_prefix_run && (CW'(i) < r_count) && r_perm[r_head + PW'(i)]) begin
                w_prefix = w_prefix + CW'(1);
            end else begin
                w_prefix_run = 1'b0;
            end
        end
    end

    // Same-cycle CDB bypass for the entry being allocated
    always_comb begin
        w_byp_s0_rdy  = i_rs_src0_rdy;
        w_byp_s0_data = i_rs_src0_data;
        w_byp_s1_rdy  = i_rs_src1_rdy;
        w_byp_s1_data = i_rs_src1_data;
        for (int c = 0; c < N_CDB; c++) begin
            if (!i_rs_src0_rdy && i_cdb_valid[c] &&
                (i_cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == i_rs_src0_tag)) begin
                w_byp_s0_rdy  = 1'b1;
                w_byp_s0_data = i_cdb_result[c*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_byp_s0_rdy  = w_byp_s0_rdy;
            end
            if (!i_rs_src1_rdy && i_cdb_valid[c] &&
                (i_cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == i_rs_src1_tag)) begin
                w_byp_s1_rdy  = 1'b1;
                w_byp_s1_data = i_cdb_result[c*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_byp_s1_rdy  = w_byp_s1_rdy;
            end
        end
    end

    // Next-state for every entry and for the head/tail/count bookkeeping
    always_comb begin
        w_valid_n    = r_valid;
        w_s0_rdy_n   = r_s0_rdy;
        w_s1_rdy_n   = r_s1_rdy;
        w_issued_n   = r_issued;
        w_agu_comp_n = r_agu_comp;
        w_perm_n     = r_perm;
        for (int i = 0; i < STQ_DEPTH; i++) begin
            w_tag_n[i]     = r_tag[i];
            w_s0_tag_n[i]  = r_s0_tag[i];
            w_s1_tag_n[i]  = r_s1_tag[i];
            w_s0_data_n[i] = r_s0_data[i];
            w_s1_data_n[i] = r_s1_data[i];
            w_state_n[i]   = r_state[i];
        end
        w_head_n  = r_head;
        w_tail_n  = r_tail;
        w_count_n = r_count;

        for (int i = 0; i < STQ_DEPTH; i++) begin
            if (r_valid[i]) begin
                // Operand wakeup; ready operands are never overwritten, so
                // src0 keeps the AGU address once it has been absorbed.
                for (int c = 0; c < N_CDB; c++) begin
                    if (i_cdb_valid[c] && !r_s0_rdy[i] &&
                        (i_cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == r_s0_tag[i])) begin
                        w_s0_rdy_n[i]  = 1'b1;
                        w_s0_data_n[i] = i_cdb_result[c*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        w_s0_rdy_n[i]  = w_s0_rdy_n[i];
                    end
                    if (i_cdb_valid[c] && !r_s1_rdy[i] &&
                        (i_cdb_tag[c*TAG_WIDTH +: TAG_WIDTH] == r_s1_tag[i])) begin
                        w_s1_rdy_n[i]  = 1'b1;
                        w_s1_data_n[i] = i_cdb_result[c*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        w_s1_rdy_n[i]  = w_s1_rdy_n[i];
                    end
                end
                // AGU address return; only an issued live entry can match
                if (i_agu_valid && r_issued[i] && !r_agu_comp[i] && (i_agu_tag == r_tag[i])) begin
                    w_s0_data_n[i]  = i_agu_result;
                    w_agu_comp_n[i] = 1'b1;
                end else begin
                    w_agu_comp_n[i] = w_agu_comp_n[i];
                end
                if (w_commit_hit[i] && !i_flush) begin
                    w_perm_n[i] = 1'b1;
                end else begin
                    w_perm_n[i] = w_perm_n[i];
                end
            end else begin
                w_valid_n[i] = 1'b0;
            end
        end

        if (w_issue_fire) begin
            w_issued_n[w_issue_idx] = 1'b1;
        end else begin
            w_issued_n = w_issued_n;
        end

        if (w_alloc) begin
            w_valid_n[r_tail]    = 1'b1;
            w_tag_n[r_tail]      = i_rs_tag;
            w_s0_tag_n[r_tail]   = i_rs_src0_tag;
            w_s1_tag_n[r_tail]   = i_rs_src1_tag;
            w_s0_rdy_n[r_tail]   = w_byp_s0_rdy;
            w_s1_rdy_n[r_tail]   = w_byp_s1_rdy;
            w_s0_data_n[r_tail]  = w_byp_s0_data;
            w_s1_data_n[r_tail]  = w_byp_s1_data;
            w_issued_n[r_tail]   = 1'b0;
            w_agu_comp_n[r_tail] = 1'b0;
            w_perm_n[r_tail]     = 1'b0;
        end else begin
            w_valid_n = w_valid_n;
        end

        if (w_pop) begin
            w_valid_n[r_head] = 1'b0;
            w_perm_n[r_head]  = 1'b0;
        end else begin
            w_valid_n = w_valid_n;
        end

        if (i_flush) begin
            // Keep the committed prefix. A pop during flush always comes from
            // that prefix because same-cycle commits are ignored under flush.
            for (int i = 0; i < STQ_DEPTH; i++) begin
                if (CW'(i) >= w_prefix) begin
                    w_valid_n[r_head + PW'(i)] = 1'b0;
                    w_perm_n[r_head + PW'(i)]  = 1'b0;
                end else begin
                    w_valid_n = w_valid_n;
                end
            end
            w_head_n  = r_head + PW'(w_pop);
            w_tail_n  = r_head + PW'(w_prefix);
            w_count_n = w_prefix - CW'(w_pop);
        end else begin
            w_head_n  = r_head + PW'(w_pop);
            w_tail_n  = r_tail + PW'(w_alloc);
            w_count_n = r_count + CW'(w_alloc) - CW'(w_pop);
        end

        for (int i = 0; i < STQ_DEPTH; i++) begin
            if (w_agu_comp_n[i]) begin
                w_state_n[i] = ST_ADDR_DONE;
            end else if (w_s0_rdy_n[i] && w_s1_rdy_n[i]) begin
                w_state_n[i] = ST_WAIT_AGU;
            end else begin
                w_state_n[i] = ST_WAIT_REG;
            end
        end
    end

    // State register for all entries and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_s0_rdy   <= '0;
            r_s1_rdy   <= '0;
            r_issued   <= '0;
            r_agu_comp <= '0;
            r_perm     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int i = 0; i < STQ_DEPTH; i++) begin
                r_tag[i]     <= '0;
                r_s0_tag[i]  <= '0;
                r_s1_tag[i]  <= '0;
                r_s0_data[i] <= '0;
                r_s1_data[i] <= '0;
                r_state[i]   <= ST_WAIT_REG;
            end
        end else begin
            r_valid    <= w_valid_n;
            r_s0_rdy   <= w_s0_rdy_n;
            r_s1_rdy   <= w_s1_rdy_n;
            r_issued   <= w_issued_n;
            r_agu_comp <= w_agu_comp_n;
            r_perm     <= w_perm_n;
            r_head     <= w_head_n;
            r_tail     <= w_tail_n;
            r_count    <= w_count_n;
            for (int i = 0; i < STQ_DEPTH; i++) begin
                r_tag[i]     <= w_tag_n[i];
                r_s0_tag[i]  <= w_s0_tag_n[i];
                r_s1_tag[i]  <= w_s1_tag_n[i];
                r_s0_data[i] <= w_s0_data_n[i];
                r_s1_data[i] <= w_s1_data_n[i];
                r_state[i]   <= w_state_n[i];
            end
        end
    end

    // AGU offer: selected entry, zeroed when nothing is eligible
    always_comb begin
        o_agu_read_rdy  = w_issue_found;
        o_agu_tag       = '0;
        o_agu_src0_data = '0;
        o_agu_src1_data = '0;
        if (w_issue_found) begin
            o_agu_tag       = r_tag[w_issue_idx];
            o_agu_src0_data = r_s0_data[w_issue_idx];
            o_agu_src1_data = r_s1_data[w_issue_idx];
        end else begin
            o_agu_tag       = '0;
        end
    end

    // Memory offer: head entry; a commit arriving this cycle already qualifies it
    always_comb begin
        o_mem_read_rdy = r_valid[r_head] && (r_state[r_head] == ST_ADDR_DONE) &&
                         (r_perm[r_head] || (w_commit_hit[r_head] && !i_flush));
        o_mem_tag      = '0;
        o_mem_addr     = '0;
        o_mem_data     = '0;
        o_mem_agu_comp = 1'b0;
        if (r_valid[r_head]) begin
            o_mem_tag      = r_tag[r_head];
            o_mem_addr     = r_s0_data[r_head];
            o_mem_data     = r_s1_data[r_head];
            o_mem_agu_comp = r_agu_comp[r_head];
        end else begin
            o_mem_agu_comp = 1'b0;
        end
    end

endmodule
